// File: rtl/hash_req_issuer.sv
// hash_req_issuer: queues host search/insert commands, issues them one at a time to the CAM, returns ordered responses.
// Optional HASH_REQ_TIMEOUT_EN abandons a CAM op after 2**TOW-1 WAIT cycles.
module hash_req_issuer #(
  parameter int DW  = 20,
  parameter int RW  = 20,
  parameter int FAW = 2,
  parameter int TOW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_op_i,
  input  logic [RW+DW-1:0] cmd_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_op_o,
  output logic             rsp_exist_o,
  output logic             rsp_timeout_o,
  output logic [RW+DW-1:0] rsp_result_o,
  output logic             insert_o,
  output logic [RW+DW-1:0] insert_data_o,
  input  logic             insert_end_i,
  output logic             search_o,
  output logic [DW-1:0]    search_data_o,
  input  logic             search_exist_i,
  input  logic             search_end_i,
  input  logic [RW+DW-1:0] search_result_i,
  output logic             busy_o
);
  localparam int W = RW + DW;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [W:0] mem_q [2**FAW];
  logic [FAW:0] wp_q, rp_q, wp_d, rp_d;
  logic op_q, op_d, rsp_op_q, rsp_op_d, exist_q, exist_d, tmo_q, tmo_d;
  logic [W-1:0] data_q, data_d, res_q, res_d, ins_data_q;
  logic [DW-1:0] srch_data_q;
  logic ins_q, srch_q, valid_q, busy_q;
  logic full, empty, push, pop, done, to_hit;
  logic [TOW-1:0] to_q;
`ifdef HASH_REQ_TIMEOUT_EN
  // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk)
    if (!rst_n) to_q <= '0;
    else to_q <= (state_q == WAIT) ? to_q + TOW'(1) : '0;
`else
  assign to_q = '0;
`endif
  assign to_hit = &to_q;
  assign full  = (wp_q[FAW] != rp_q[FAW]) && (wp_q[FAW-1:0] == rp_q[FAW-1:0]);
  assign empty = wp_q == rp_q;
  assign push  = cmd_valid_i && !full;
  assign pop   = state_q == IDLE && !empty;
  assign wp_d  = wp_q + (FAW+1)'(push);
  assign rp_d  = rp_q + (FAW+1)'(pop);
  assign done  = op_q ? insert_end_i : search_end_i;
  assign cmd_ready_o   = !full;
  assign rsp_valid_o   = valid_q;
  assign rsp_op_o      = rsp_op_q;
  assign rsp_exist_o   = exist_q;
  assign rsp_timeout_o = tmo_q;
  assign rsp_result_o  = res_q;
  assign insert_o      = ins_q;
  assign insert_data_o = ins_data_q;
  assign search_o      = srch_q;
  assign search_data_o = srch_data_q;
  assign busy_o        = busy_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    rsp_op_d = rsp_op_q;
    exist_d  = exist_q;
    tmo_d    = tmo_q;
    res_d    = res_q;
    case (state_q)
      IDLE: if (!empty) begin
        state_d = ISSUE;
        {op_d, data_d} = mem_q[rp_q[FAW-1:0]];
      end
      ISSUE: state_d = WAIT;
      WAIT: if (done || to_hit) begin
        state_d  = RESP;
        rsp_op_d = op_q;
        tmo_d    = !done;
        exist_d  = done && !op_q && search_exist_i;
        res_d    = !done ? '0 : op_q ? data_q : search_result_i;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
    endcase
  end
  // Outputs are registered from next-state values so the strobe lines up with ISSUE.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      op_q        <= 1'b0;
      data_q      <= '0;
      rsp_op_q    <= 1'b0;
      exist_q     <= 1'b0;
      tmo_q       <= 1'b0;
      res_q       <= '0;
      valid_q     <= 1'b0;
      ins_q       <= 1'b0;
      srch_q      <= 1'b0;
      ins_data_q  <= '0;
      srch_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (push) mem_q[wp_q[FAW-1:0]] <= {cmd_op_i, cmd_data_i};
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rsp_op_q    <= rsp_op_d;
      exist_q     <= exist_d;
      tmo_q       <= tmo_d;
      res_q       <= res_d;
      valid_q     <= state_d == RESP;
      ins_q       <= state_d == ISSUE && op_d;
      srch_q      <= state_d == ISSUE && !op_d;
      ins_data_q  <= (state_d == ISSUE || state_d == WAIT) && op_d ? data_d : '0;
      srch_data_q <= (state_d == ISSUE || state_d == WAIT) && !op_d ? data_d[DW-1:0] : '0;
      busy_q      <= state_d != IDLE || wp_d != rp_d;
    end
endmodule

// File: tb/tb_hash_req_issuer.sv
// tb_hash_req_issuer: directed stimulus with a response scoreboard and a behavioural CAM responder.
module tb_hash_req_issuer;
  logic clk = 0, rst_n = 0;
  logic cmd_valid_i = 0, cmd_ready_o, cmd_op_i = 0;
  logic [39:0] cmd_data_i = '0;
  logic rsp_valid_o, rsp_ready_i = 1, rsp_op_o, rsp_exist_o, rsp_timeout_o;
  logic [39:0] rsp_result_o, insert_data_o, search_result_i;
  logic insert_o, insert_end_i, search_o, search_exist_i, search_end_i, busy_o;
  logic [19:0] search_data_o;
  logic cam_end = 0, spur_end = 0;
  logic cam_en = 1, cam_wrong = 0, cam_exist = 0;
  logic [39:0] cam_result = '0;
  int cam_delay = 3;
  int pass_cnt = 0, tot_cnt = 0;
  logic [42:0] exp_q[$];
  logic [39:0] t3_data[5] = '{40'h0A00000001, 40'h0B00000002, 40'h0C00000003, 40'h0D00000004, 40'h0E00000005};

  assign search_end_i = cam_end | spur_end;

  hash_req_issuer #(.DW(20), .RW(20), .FAW(2), .TOW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_op_o(rsp_op_o), .rsp_exist_o(rsp_exist_o),
    .rsp_timeout_o(rsp_timeout_o), .rsp_result_o(rsp_result_o),
    .insert_o(insert_o), .insert_data_o(insert_data_o), .insert_end_i(insert_end_i),
    .search_o(search_o), .search_data_o(search_data_o), .search_exist_i(search_exist_i),
    .search_end_i(search_end_i), .search_result_i(search_result_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic op, input logic [39:0] d);
    int n = 0;
    cmd_valid_i = 1; cmd_op_i = op; cmd_data_i = d;
    while (!cmd_ready_o && n < 50) begin tick(); n++; end
    chk("cmd_accept", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin tick(); n++; end
    chk("drain", exp_q.size(), 0);
    tick();
  endtask

  // CAM responder: answers each strobe after cam_delay cycles; cam_wrong first sends the other op's end pulse.
  initial begin
    insert_end_i = 0; search_exist_i = 0; search_result_i = '0;
    forever begin
      tick();
      if (cam_en && (search_o || insert_o)) begin
        automatic logic s = search_o;
        automatic int d = cam_delay;
        if (cam_wrong) begin
          tick();
          if (s) insert_end_i = 1; else cam_end = 1;
          tick();
          insert_end_i = 0; cam_end = 0;
        end
        if (d > 1) tick(d - 1);
        if (s) begin cam_end = 1; search_exist_i = cam_exist; search_result_i = cam_result; end
        else insert_end_i = 1;
        tick();
        cam_end = 0; insert_end_i = 0; search_exist_i = 0; search_result_i = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", {rsp_op_o, rsp_exist_o, rsp_timeout_o, rsp_result_o}, 64'hDEAD);
        else chk("rsp", {rsp_op_o, rsp_exist_o, rsp_timeout_o, rsp_result_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_strobes", {insert_o, search_o}, 0);
    chk("rst_data", {insert_data_o, search_data_o, rsp_result_o}, 0);
    rst_n = 1;
    tick();
    // T1: single search with hit
    cam_delay = 3; cam_exist = 1; cam_result = 40'h1234500ABC;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 40'h1234500ABC});
    send(0, 40'h0000000ABC);
    chk("t1_idle_before_strobe", search_o, 0);
    tick();
    chk("t1_strobe", search_o, 1);
    chk("t1_key", search_data_o, 20'h00ABC);
    chk("t1_no_insert", insert_o, 0);
    tick();
    chk("t1_strobe_1cyc", search_o, 0);
    chk("t1_key_held", search_data_o, 20'h00ABC);
    tick();
    chk("t1_valid_early", rsp_valid_o, 0);
    tick();
    chk("t1_valid", rsp_valid_o, 1);
    drain(20);
    chk("t1_key_cleared", search_data_o, 0);
    // T2: insert echo
    cam_delay = 2;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 40'h0000100002});
    send(1, 40'h0000100002);
    tick();
    chk("t2_strobe", insert_o, 1);
    chk("t2_data", insert_data_o, 40'h0000100002);
    tick();
    chk("t2_strobe_1cyc", insert_o, 0);
    drain(20);
    chk("t2_data_cleared", insert_data_o, 0);
    // T3: fill FIFO with responses blocked, then release
    rsp_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b1, 1'b0, 1'b0, t3_data[i]});
      send(1, t3_data[i]);
    end
    chk("t3_full", cmd_ready_o, 0);
    tick(8);
    chk("t3_still_full", cmd_ready_o, 0);
    chk("t3_valid_held", rsp_valid_o, 1);
    chk("t3_result_held", rsp_result_o, 40'h0A00000001);
    chk("t3_busy", busy_o, 1);
    rsp_ready_i = 1;
    drain(200);
    chk("t3_ready_after", cmd_ready_o, 1);
    chk("t3_idle_after", busy_o, 0);
    // T4: spurious end pulses
    spur_end = 1;
    tick();
    spur_end = 0;
    tick(3);
    chk("t4_no_rsp", rsp_valid_o, 0);
    chk("t4_idle", busy_o, 0);
    cam_wrong = 1; cam_delay = 3; cam_exist = 1; cam_result = 40'hBEEF000777;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 40'hBEEF000777});
    send(0, 40'h0000000777);
    tick(3);
    chk("t4_wrong_end_ignored", rsp_valid_o, 0);
    drain(30);
    cam_wrong = 0;
    // T5: reset during WAIT abandons the op
    cam_en = 0;
    send(0, 40'h0000000555);
    tick(4);
    chk("t5_waiting", busy_o, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("t5_busy", busy_o, 0);
    chk("t5_ready", cmd_ready_o, 1);
    chk("t5_valid", rsp_valid_o, 0);
    chk("t5_key", search_data_o, 0);
    tick(10);
    cam_en = 1; cam_delay = 2; cam_exist = 0; cam_result = 40'h0000300003;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 40'h0000300003});
    send(0, 40'h0000000003);
    drain(20);
`ifdef HASH_REQ_TIMEOUT_EN
    // T6: timeout with late end pulse
    cam_en = 0;
    exp_q.push_back({1'b0, 1'b0, 1'b1, 40'h0});
    send(0, 40'h0000000999);
    drain(40);
    spur_end = 1;
    tick();
    spur_end = 0;
    tick(4);
    chk("t6_late_ignored", rsp_valid_o, 0);
    chk("t6_idle", busy_o, 0);
    cam_en = 1;
`endif
    tick(5);
    chk("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
